// File: rtl/spi_slave_axis_ingress.sv
// -----------------------------------------------------------------------------
// spi_slave_axis_ingress
//
// This is the receive half of the SPI slave. It samples MOSI on the rising
// edge of spi_clk and assembles the bits into bytes. Each completed byte is
// presented on an 8-bit AXI-Stream master port, which feeds the register-file
// ingress logic.
//
// The first byte of every chip-select transaction is tagged as the header
// (m_axis_tuser = 1). A 2-entry buffer lets the consumer stall for about one
// byte time. A byte that arrives while the buffer is full is dropped, and the
// sticky overflow flag is set.
//
// Optional feature macro: SPI_INGRESS_MTU_CHECK_EN
//   When defined, payload bytes after the header are counted. The
//   (MTU_SIZE+1)-th payload byte sends the block into a DISCARD state. That
//   byte and every later byte are dropped until chip-select deasserts, and
//   the sticky mtu_error flag is set.
//   When undefined, every byte is forwarded and mtu_error is tied to 0.
//
// Parameters:
//   MSB_FIRST  1 = first sampled bits land in the MSB, 0 = LSB first
//   MOSI_SIZE  data lines per clock, 1 or 2
//   MTU_SIZE   maximum payload bytes after the header (MTU check only)
//
// Ports:
//   spi_clk        SPI serial clock; the only clock, rising edge
//   spi_csn        chip select; high = asynchronous reset
//   spi_mosi       serial data, MOSI_SIZE bits per edge
//   m_axis_tdata   head-of-buffer byte
//   m_axis_tvalid  buffer non-empty
//   m_axis_tready  consumer accepts the head byte on this edge
//   m_axis_tuser   1 = head byte is the transaction header
//   overflow       sticky: a completed byte was dropped on a full buffer
//   mtu_error      sticky: a payload byte beyond MTU_SIZE was dropped
// -----------------------------------------------------------------------------
module spi_slave_axis_ingress #(
    parameter int MSB_FIRST = 1,
    parameter int MOSI_SIZE = 1,
    parameter int MTU_SIZE  = 16
) (
    input  logic                 spi_clk,
    input  logic                 spi_csn,
    input  logic [MOSI_SIZE-1:0] spi_mosi,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 overflow,
    output logic                 mtu_error
);

    generate
        if (MOSI_SIZE != 1 && MOSI_SIZE != 2) begin : g_bad_mosi_size
            $error("spi_slave_axis_ingress: MOSI_SIZE must be 1 or 2");
        end
        if (MTU_SIZE < 1) begin : g_bad_mtu_size
            $error("spi_slave_axis_ingress: MTU_SIZE must be at least 1");
        end
    endgenerate

    // Number of already-received bits held between edges.
    localparam int          PW   = 8 - MOSI_SIZE;
    localparam logic [2:0]  STEP = 3'(MOSI_SIZE);
    localparam logic [2:0]  LAST = 3'(8 - MOSI_SIZE);

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1
`ifdef SPI_INGRESS_MTU_CHECK_EN
        ,
        S_DISCARD = 2'd2
`endif
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Bit assembly
    // ------------------------------------------------------------------
    logic [2:0]    bit_cnt;
    logic [PW-1:0] partial;    // bits received so far in the current byte
    logic [7:0]    byte_full;  // partial plus this edge's bits
    logic [PW-1:0] partial_d;
    logic          byte_done;

    // Only the bits that are still needed are stored, so the register has no
    // dead bits. byte_full is the completed byte on the edge that finishes it.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            always_comb begin
                byte_full = {partial, spi_mosi};
                partial_d = byte_full[PW-1:0];
            end
        end else begin : g_lsb_first
            always_comb begin
                byte_full = {spi_mosi, partial};
                partial_d = byte_full[7:MOSI_SIZE];
            end
        end
    endgenerate

    assign byte_done = (bit_cnt == LAST);

    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            bit_cnt <= '0;
            partial <= '0;
        end else begin
            bit_cnt <= bit_cnt + STEP;
            partial <= partial_d;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry buffer of {tuser, tdata}
    // ------------------------------------------------------------------
    logic [8:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       full;
    logic       pop;
    logic       push;
    logic       push_req;
    logic       push_user;
    logic       drop_full;
    logic       drop_mtu;
    logic       pay_inc;

    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = mem[rd_ptr][7:0];
    assign m_axis_tuser  = mem[rd_ptr][8];
    assign full          = (count == 2'd2);
    assign pop           = m_axis_tvalid && m_axis_tready;

    // On a full buffer a same-edge pop frees the slot, so the push still fits.
    assign push      = push_req && (!full || pop);
    assign drop_full = push_req && full && !pop;

    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_user, byte_full};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction state machine
    // ------------------------------------------------------------------
`ifdef SPI_INGRESS_MTU_CHECK_EN
    localparam int          CW      = $clog2(MTU_SIZE + 2);
    localparam logic [CW-1:0] MTU_CNT = CW'(MTU_SIZE);

    logic [CW-1:0] pay_cnt;
`endif

    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            state_q <= S_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        push_user = 1'b0;
        drop_mtu  = 1'b0;
        pay_inc   = 1'b0;
        case (state_q)
            S_HEADER: begin
                // The state advances even if the header itself is dropped.
                if (byte_done) begin
                    push_req  = 1'b1;
                    push_user = 1'b1;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (byte_done) begin
`ifdef SPI_INGRESS_MTU_CHECK_EN
                    if (pay_cnt == MTU_CNT) begin
                        drop_mtu = 1'b1;
                        state_d  = S_DISCARD;
                    end else begin
                        push_req = 1'b1;
                        pay_inc  = 1'b1;
                    end
`else
                    push_req = 1'b1;
                    pay_inc  = 1'b1;
`endif
                end
            end
`ifdef SPI_INGRESS_MTU_CHECK_EN
            S_DISCARD: begin
                state_d = S_DISCARD;
            end
`endif
            default: begin
                state_d = S_HEADER;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky error flags and payload counter
    // ------------------------------------------------------------------
    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            overflow <= 1'b0;
        end else if (drop_full) begin
            overflow <= 1'b1;
        end
    end

`ifdef SPI_INGRESS_MTU_CHECK_EN
    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            pay_cnt   <= '0;
            mtu_error <= 1'b0;
        end else begin
            if (pay_inc && (pay_cnt != '1)) begin
                pay_cnt <= pay_cnt + 1'b1;
            end
            if (drop_mtu) begin
                mtu_error <= 1'b1;
            end
        end
    end
`else
    assign mtu_error = 1'b0;

    // Without the MTU check these strobes have no consumer.
    logic unused_mtu;
    assign unused_mtu = drop_mtu ^ pay_inc;
`endif

endmodule

// File: tb/tb_spi_slave_axis_ingress.sv
module tb_spi_slave_axis_ingress;

    logic spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    // dut0: MSB first, 1 data line, MTU_SIZE = 2
    logic       csn0;
    logic [0:0] mosi0;
    logic [7:0] tdata0;
    logic       tvalid0;
    logic       tready0;
    logic       tuser0;
    logic       ovf0;
    logic       mtu0;

    // dut1: LSB first, 2 data lines
    logic       csn1;
    logic [1:0] mosi1;
    logic [7:0] tdata1;
    logic       tvalid1;
    logic       tready1;
    logic       tuser1;
    logic       ovf1;
    logic       mtu1;

    int checks = 0;
    int errors = 0;

    spi_slave_axis_ingress #(
        .MSB_FIRST (1),
        .MOSI_SIZE (1),
        .MTU_SIZE  (2)
    ) dut0 (
        .spi_clk       (spi_clk),
        .spi_csn       (csn0),
        .spi_mosi      (mosi0),
        .m_axis_tdata  (tdata0),
        .m_axis_tvalid (tvalid0),
        .m_axis_tready (tready0),
        .m_axis_tuser  (tuser0),
        .overflow      (ovf0),
        .mtu_error     (mtu0)
    );

    spi_slave_axis_ingress #(
        .MSB_FIRST (0),
        .MOSI_SIZE (2),
        .MTU_SIZE  (16)
    ) dut1 (
        .spi_clk       (spi_clk),
        .spi_csn       (csn1),
        .spi_mosi      (mosi1),
        .m_axis_tdata  (tdata1),
        .m_axis_tvalid (tvalid1),
        .m_axis_tready (tready1),
        .m_axis_tuser  (tuser1),
        .overflow      (ovf1),
        .mtu_error     (mtu1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat0(input string tag, input logic v, input logic [7:0] d, input logic u);
        chk({tag, ".tvalid"}, 32'(tvalid0), 32'(v));
        chk({tag, ".tdata"},  32'(tdata0),  32'(d));
        chk({tag, ".tuser"},  32'(tuser0),  32'(u));
    endtask

    // Advance one rising edge; inputs then change 1 time unit after that edge.
    task automatic tick();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic send_bits0(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi0[0] = b[7 - i];
            tick();
        end
    endtask

    task automatic restart0();
        csn0 = 1'b1;
        tick();
        tick();
        csn0 = 1'b0;
    endtask

    initial begin
        csn0    = 1'b1;
        csn1    = 1'b1;
        mosi0   = '0;
        mosi1   = '0;
        tready0 = 1'b1;
        tready1 = 1'b1;
        tick();
        tick();
        tick();

        // Reset state
        chk_beat0("rst0", 1'b0, 8'h00, 1'b0);
        chk("rst0.overflow", 32'(ovf0), 32'd0);
        chk("rst0.mtu_error", 32'(mtu0), 32'd0);
        chk("rst1.tvalid", 32'(tvalid1), 32'd0);
        chk("rst1.tdata", 32'(tdata1), 32'h00);

        // A5 then 3C, MSB first, 1 line, consumer always ready
        csn0 = 1'b0;
        send_bits0(8'hA5, 7);
        chk("t1.edge7.tvalid", 32'(tvalid0), 32'd0);
        send_bits0(8'hA5 << 7, 1);
        chk_beat0("t1.hdr", 1'b1, 8'hA5, 1'b1);
        send_bits0(8'h3C, 8);
        chk_beat0("t1.pay", 1'b1, 8'h3C, 1'b0);

        // LSB first, 2 lines: pairs 01,10,11,00 -> 0x39
        csn1  = 1'b0;
        mosi1 = 2'b01; tick();
        mosi1 = 2'b10; tick();
        mosi1 = 2'b11; tick();
        chk("t2.edge3.tvalid", 32'(tvalid1), 32'd0);
        mosi1 = 2'b00; tick();
        chk("t2.tvalid", 32'(tvalid1), 32'd1);
        chk("t2.tdata", 32'(tdata1), 32'h39);
        chk("t2.tuser", 32'(tuser1), 32'd1);
        csn1 = 1'b1;

        // MTU: header plus 3 payload bytes with MTU_SIZE = 2
        restart0();
        chk_beat0("t3.restart", 1'b0, 8'h00, 1'b0);
        send_bits0(8'h80, 8);
        chk_beat0("t3.hdr", 1'b1, 8'h80, 1'b1);
        send_bits0(8'h01, 8);
        chk_beat0("t3.p1", 1'b1, 8'h01, 1'b0);
        send_bits0(8'h02, 8);
        chk_beat0("t3.p2", 1'b1, 8'h02, 1'b0);
        send_bits0(8'h03, 8);
`ifdef SPI_INGRESS_MTU_CHECK_EN
        chk("t3.p3.tvalid", 32'(tvalid0), 32'd0);
        chk("t3.mtu_error", 32'(mtu0), 32'd1);
`else
        chk_beat0("t3.p3", 1'b1, 8'h03, 1'b0);
        chk("t3.mtu_error", 32'(mtu0), 32'd0);
`endif
        chk("t3.overflow", 32'(ovf0), 32'd0);

        // Overflow: consumer stalled, three bytes
        restart0();
        tready0 = 1'b0;
        send_bits0(8'h11, 8);
        send_bits0(8'h22, 8);
        chk("t4.edge16.overflow", 32'(ovf0), 32'd0);
        send_bits0(8'h33, 8);
        chk("t4.edge24.overflow", 32'(ovf0), 32'd1);
        chk_beat0("t4.head", 1'b1, 8'h11, 1'b1);
        tready0 = 1'b1;
        tick();
        chk_beat0("t4.pop1", 1'b1, 8'h22, 1'b0);
        tick();
        chk("t4.pop2.tvalid", 32'(tvalid0), 32'd0);
        chk("t4.sticky", 32'(ovf0), 32'd1);

        // Full buffer with pop and push on the same edge
        restart0();
        tready0 = 1'b0;
        send_bits0(8'h40, 8);
        send_bits0(8'h55, 8);
        chk_beat0("t5.full", 1'b1, 8'h40, 1'b1);
        send_bits0(8'h66, 7);
        tready0 = 1'b1;
        send_bits0(8'h66 << 7, 1);
        chk("t5.overflow", 32'(ovf0), 32'd0);
        chk_beat0("t5.after", 1'b1, 8'h55, 1'b0);
        tready0 = 1'b0;
        tick();
        chk_beat0("t5.stall", 1'b1, 8'h55, 1'b0);
        tready0 = 1'b1;
        tick();
        chk_beat0("t5.pop1", 1'b1, 8'h66, 1'b0);
        tick();
        chk("t5.pop2.tvalid", 32'(tvalid0), 32'd0);

        // Chip select raised mid-byte with a byte buffered
        restart0();
        tready0 = 1'b0;
        send_bits0(8'h77, 8);
        send_bits0(8'hFF, 5);
        chk_beat0("t6.before", 1'b1, 8'h77, 1'b1);
        csn0 = 1'b1;
        #1;
        chk_beat0("t6.abort", 1'b0, 8'h00, 1'b0);
        chk("t6.overflow", 32'(ovf0), 32'd0);
        tick();
        csn0    = 1'b0;
        tready0 = 1'b1;
        send_bits0(8'h9A, 8);
        chk_beat0("t6.newhdr", 1'b1, 8'h9A, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
